// File: rtl/dma_ctrl.sv
// dma_ctrl: single-channel word DMA between an external DRAM port and the
// CPU's SRAM. A command from the CPU freezes the pipeline (stall) and copies
// dmaWidth 32-bit words one at a time, DRAM->SRAM or SRAM->DRAM. A
// one-cycle done pulse then releases the CPU.
//
// Ports
//   clk, reset          : clock (rising edge) / asynchronous active-low reset
//   dmaCmd              : 00 none, 01 DRAM->SRAM, 10 SRAM->DRAM, 11 ignored
//   dmaSrcAddress       : byte address of the first source word
//   dmaDstAddress       : byte address of the first destination word
//   dmaWidth            : word count, 0..1023
//   stall               : CPU freeze and SRAM-port ownership
//   done                : one-cycle completion pulse
//   sram*               : SRAM port; read is combinational, write is on the clock edge
//   dram*               : DRAM request/ack port; read data is valid with dramAck
module dma_ctrl #(
  parameter int SRAM_WORDS = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  dmaCmd,
  input  logic [31:0] dmaSrcAddress,
  input  logic [31:0] dmaDstAddress,
  input  logic [9:0]  dmaWidth,
  output logic        stall,
  output logic        done,
  output logic [31:0] sramAddress,
  output logic        sramWriteEnable,
  output logic [31:0] sramWriteData,
  input  logic [31:0] sramReadData,
  output logic        dramReq,
  output logic        dramWe,
  output logic [31:0] dramAddress,
  output logic [31:0] dramWriteData,
  input  logic [31:0] dramReadData,
  input  logic        dramAck
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DREAD  = 3'd1,
    SWRITE = 3'd2,
    SREAD  = 3'd3,
    DWRITE = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] src_r;
  logic [31:0] dst_r;
  logic [31:0] data_r;
  logic [9:0]  width_r;
  logic [9:0]  i_r;

  logic        cmd_go_s;
  logic        last_s;
  logic [31:0] cur_src_s;
  logic [31:0] cur_dst_s;
  logic        unused_s;

  // The SRAM decodes only byte address [15:2] modulo its depth. The index is
  // presented already folded so the address on the port is the word actually hit.
  function automatic logic [31:0] sram_word_addr(input logic [31:2] word_addr);
    logic [31:0] word_s;
    word_s = {18'd0, word_addr[15:2]} % 32'(SRAM_WORDS);
    return {word_addr[31:16], 16'd0} | (word_s << 2);
  endfunction

  // Byte-lane bits of the start addresses carry no meaning for word transfers.
  assign unused_s  = ^{dmaSrcAddress[1:0], dmaDstAddress[1:0]};

  assign cmd_go_s  = (dmaCmd == 2'b01) || (dmaCmd == 2'b10);
  assign last_s    = ((i_r + 10'd1) == width_r);
  assign cur_src_s = src_r + {20'd0, i_r, 2'b00};
  assign cur_dst_s = dst_r + {20'd0, i_r, 2'b00};

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Transfer parameters, word index and the one-word data buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_r   <= 32'd0;
      dst_r   <= 32'd0;
      width_r <= 10'd0;
      i_r     <= 10'd0;
      data_r  <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_go_s) begin
            src_r   <= {dmaSrcAddress[31:2], 2'b00};
            dst_r   <= {dmaDstAddress[31:2], 2'b00};
            width_r <= dmaWidth;
            i_r     <= 10'd0;
          end
        end
        DREAD: begin
          if (dramAck) begin
            data_r <= dramReadData;
          end
        end
        SWRITE: begin
          i_r <= i_r + 10'd1;
        end
        SREAD: begin
          data_r <= sramReadData;
        end
        DWRITE: begin
          if (dramAck) begin
            i_r <= i_r + 10'd1;
          end
        end
        DONE: begin
          i_r <= 10'd0;
        end
        default: begin
          i_r <= 10'd0;
        end
      endcase
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (dmaCmd == 2'b01) begin
          state_nxt_s = (dmaWidth == 10'd0) ? DONE : DREAD;
        end else if (dmaCmd == 2'b10) begin
          state_nxt_s = (dmaWidth == 10'd0) ? DONE : SREAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DREAD: begin
        if (dramAck) begin
          state_nxt_s = SWRITE;
        end else begin
          state_nxt_s = DREAD;
        end
      end
      SWRITE: begin
        state_nxt_s = last_s ? DONE : DREAD;
      end
      SREAD: begin
        state_nxt_s = DWRITE;
      end
      DWRITE: begin
        if (dramAck) begin
          state_nxt_s = last_s ? DONE : SREAD;
        end else begin
          state_nxt_s = DWRITE;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM outputs. stall is combinational so the CPU freezes in the very cycle
  // a command appears; it is gated by reset so it stays low while reset is held.
  always_comb begin
    stall           = 1'b0;
    done            = 1'b0;
    sramAddress     = 32'd0;
    sramWriteEnable = 1'b0;
    sramWriteData   = 32'd0;
    dramReq         = 1'b0;
    dramWe          = 1'b0;
    dramAddress     = 32'd0;
    dramWriteData   = 32'd0;
    case (state_r)
      IDLE: begin
        stall = cmd_go_s & reset;
      end
      DREAD: begin
        stall       = 1'b1;
        dramReq     = 1'b1;
        dramAddress = cur_src_s;
      end
      SWRITE: begin
        stall           = 1'b1;
        sramWriteEnable = 1'b1;
        sramAddress     = sram_word_addr(cur_dst_s[31:2]);
        sramWriteData   = data_r;
      end
      SREAD: begin
        stall       = 1'b1;
        sramAddress = sram_word_addr(cur_src_s[31:2]);
      end
      DWRITE: begin
        stall         = 1'b1;
        dramReq       = 1'b1;
        dramWe        = 1'b1;
        dramAddress   = cur_dst_s;
        dramWriteData = data_r;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Scoreboard bench for dma_ctrl: stimulus pushes the expected SRAM writes,
// DRAM reads/writes and done pulses into queues; a monitor pops and compares
// them whenever the DUT presents the matching strobe.
module tb_dma_ctrl;
  logic        clk;
  logic        reset;
  logic [1:0]  dmaCmd;
  logic [31:0] dmaSrcAddress;
  logic [31:0] dmaDstAddress;
  logic [9:0]  dmaWidth;
  logic        stall;
  logic        done;
  logic [31:0] sramAddress;
  logic        sramWriteEnable;
  logic [31:0] sramWriteData;
  logic [31:0] sramReadData;
  logic        dramReq;
  logic        dramWe;
  logic [31:0] dramAddress;
  logic [31:0] dramWriteData;
  logic [31:0] dramReadData;
  logic        dramAck;

  dma_ctrl #(.SRAM_WORDS(16384)) dut (
    .clk(clk), .reset(reset), .dmaCmd(dmaCmd),
    .dmaSrcAddress(dmaSrcAddress), .dmaDstAddress(dmaDstAddress),
    .dmaWidth(dmaWidth), .stall(stall), .done(done),
    .sramAddress(sramAddress), .sramWriteEnable(sramWriteEnable),
    .sramWriteData(sramWriteData), .sramReadData(sramReadData),
    .dramReq(dramReq), .dramWe(dramWe), .dramAddress(dramAddress),
    .dramWriteData(dramWriteData), .dramReadData(dramReadData),
    .dramAck(dramAck)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;

  xfer_t       exp_sram[$];   // a = SRAM word index
  xfer_t       exp_dwr[$];    // a = DRAM byte address
  logic [31:0] exp_drd[$];    // DRAM read byte addresses
  int          exp_done  = 0;
  int          stall_cnt = 0;
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  int          ack_delay = 0;

  logic [31:0] sram_mem [0:16383];
  logic [31:0] dram_mem [logic [31:0]];

  assign sramReadData = sram_mem[sramAddress[15:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // DRAM responder: acks after ack_delay wait cycles, returns read data with the ack.
  initial begin
    int wait_cnt;
    wait_cnt     = 0;
    dramAck      = 1'b0;
    dramReadData = 32'd0;
    forever begin
      @(negedge clk);
      if (dramReq) begin
        if (wait_cnt >= ack_delay) begin
          dramAck = 1'b1;
          dramReadData = dram_mem.exists(dramAddress) ? dram_mem[dramAddress] : 32'hDEAD_BEEF;
          wait_cnt = 0;
        end else begin
          dramAck = 1'b0;
          wait_cnt++;
        end
      end else begin
        dramAck  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: compares every DUT strobe against the head of its queue.
  initial begin
    xfer_t e;
    forever begin
      @(negedge clk);
      #2;
      if (stall) stall_cnt++;
      if (done) begin
        chk("done_expected", (exp_done > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_done > 0) exp_done--;
      end
      if (sramWriteEnable) begin
        chk("sram_write_expected", (exp_sram.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_sram.size() > 0) begin
          e = exp_sram.pop_front();
          chk("sram_index", {18'd0, sramAddress[15:2]}, e.a);
          chk("sram_data", sramWriteData, e.d);
        end
        sram_mem[sramAddress[15:2]] = sramWriteData;
      end
      if (dramReq && dramWe) begin
        chk("dram_write_expected", (exp_dwr.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_dwr.size() > 0) begin
          chk("dram_wr_addr", dramAddress, exp_dwr[0].a);
          chk("dram_wr_data", dramWriteData, exp_dwr[0].d);
          if (dramAck) void'(exp_dwr.pop_front());
        end
      end else if (dramReq) begin
        chk("dram_read_expected", (exp_drd.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_drd.size() > 0) begin
          chk("dram_rd_addr", dramAddress, exp_drd[0]);
          if (dramAck) void'(exp_drd.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  // Issue one command and wait (bounded) for its done pulse.
  task automatic run(input string tag, input logic [1:0] cmd, input logic [31:0] src,
                     input logic [31:0] dst, input logic [9:0] w, input int exp_stall);
    bit got;
    @(posedge clk); #1;
    dmaCmd = cmd; dmaSrcAddress = src; dmaDstAddress = dst; dmaWidth = w;
    stall_cnt = 0;
    #1;
    chk({tag, "_stall_in_cmd_cycle"}, {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    dmaCmd = 2'b00;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #3;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    chk({tag, "_stall_low_in_done"}, {31'd0, stall}, 32'd0);
    chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
    @(negedge clk); #3;
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    bit hit;
    reset = 1'b0; dmaCmd = 2'b01; dmaSrcAddress = 32'd0; dmaDstAddress = 32'd0; dmaWidth = 10'd1;
    sram_mem[0] = 32'd5; sram_mem[1] = 32'd7; sram_mem[33] = 32'hCAFE_0033;
    dram_mem[32'h100] = 32'h11; dram_mem[32'h104] = 32'h22; dram_mem[32'h108] = 32'h33;
    dram_mem[32'h300] = 32'hA1; dram_mem[32'h304] = 32'hB2;
    dram_mem[32'h400] = 32'h4A; dram_mem[32'h404] = 32'h4B;
    dram_mem[32'h500] = 32'h55;

    // Reset: everything low even with a command on the bus.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sram_we", {31'd0, sramWriteEnable}, 32'd0);
    chk("rst_dram_req", {31'd0, dramReq}, 32'd0);
    chk("rst_dram_we", {31'd0, dramWe}, 32'd0);
    dmaCmd = 2'b00;
    @(negedge clk); reset = 1'b1;

    // DRAM->SRAM, 3 words, zero-wait acks: 1+2*3 stall cycles.
    ack_delay = 0;
    exp_drd.push_back(32'h100); exp_drd.push_back(32'h104); exp_drd.push_back(32'h108);
    exp_sram.push_back('{a: 32'd16, d: 32'h11});
    exp_sram.push_back('{a: 32'd17, d: 32'h22});
    exp_sram.push_back('{a: 32'd18, d: 32'h33});
    exp_done++;
    run("d2s3", 2'b01, 32'h100, 32'h40, 10'd3, 7);
    chk("d2s3_sram16", sram_mem[16], 32'h11);
    chk("d2s3_sram18", sram_mem[18], 32'h33);

    // SRAM->DRAM, 2 words, 3 wait cycles per ack: 1+2*(1+4) stall cycles.
    ack_delay = 3;
    exp_dwr.push_back('{a: 32'h200, d: 32'd5});
    exp_dwr.push_back('{a: 32'h204, d: 32'd7});
    exp_done++;
    run("s2d2", 2'b10, 32'h0, 32'h200, 10'd2, 11);

    // Zero width: one stall cycle, straight to DONE, no memory traffic.
    ack_delay = 0;
    exp_done++;
    run("w0", 2'b01, 32'h100, 32'h40, 10'd0, 1);

    // Illegal command: ignored entirely.
    @(posedge clk); #1;
    dmaCmd = 2'b11; dmaWidth = 10'd4; stall_cnt = 0;
    #1;
    chk("cmd11_stall", {31'd0, stall}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    dmaCmd = 2'b00;
    chk("cmd11_stall_cycles", 32'(stall_cnt), 32'd0);

    // Destination at the top of SRAM wraps to index 0.
    exp_drd.push_back(32'h300); exp_drd.push_back(32'h304);
    exp_sram.push_back('{a: 32'd16383, d: 32'hA1});
    exp_sram.push_back('{a: 32'd0, d: 32'hB2});
    exp_done++;
    run("wrap", 2'b01, 32'h300, 32'hFFFC, 10'd2, 5);

    // Reset during the DRAM read of word 1 of 4.
    ack_delay = 3;
    exp_drd.push_back(32'h400); exp_drd.push_back(32'h404);
    exp_sram.push_back('{a: 32'd32, d: 32'h4A});
    @(posedge clk); #1;
    dmaCmd = 2'b01; dmaSrcAddress = 32'h400; dmaDstAddress = 32'h80; dmaWidth = 10'd4;
    @(posedge clk); #1;
    dmaCmd = 2'b00;
    hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (dramReq && (dramAddress == 32'h404)) begin
        hit = 1'b1;
        break;
      end
    end
    chk("abort_reached_word1", {31'd0, hit}, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_dram_req", {31'd0, dramReq}, 32'd0);
    chk("abort_sram_we", {31'd0, sramWriteEnable}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    exp_drd.delete();
    chk("abort_sram32", sram_mem[32], 32'h4A);
    chk("abort_sram33", sram_mem[33], 32'hCAFE_0033);

    // First command after reset starts at word 0.
    ack_delay = 0;
    exp_drd.push_back(32'h500);
    exp_sram.push_back('{a: 32'd36, d: 32'h55});
    exp_done++;
    run("post_rst", 2'b01, 32'h500, 32'h90, 10'd1, 3);

    repeat (3) @(posedge clk);
    #1;
    chk("left_sram_q", 32'(exp_sram.size()), 32'd0);
    chk("left_dwr_q", 32'(exp_dwr.size()), 32'd0);
    chk("left_drd_q", 32'(exp_drd.size()), 32'd0);
    chk("left_done", 32'(exp_done), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
